// File: rtl/id_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_hazard_ctrl_pkg
//  Description : Shared constants, forwarding-select encodings and the
//                shadow-entry layout for the decode-stage issue controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_hazard_ctrl_pkg;

    // Default geometry of the controller
    localparam int C_REG_LOG = 5;
    localparam int C_NSRC    = 3;
    localparam int C_CNT_W   = 32;

    // Forwarding select encodings (per source operand)
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // Shadow-entry field widths
    localparam int C_ENT_V_W    = 1;
    localparam int C_ENT_RD_W   = C_REG_LOG;
    localparam int C_ENT_WEN_W  = 1;
    localparam int C_ENT_LOAD_W = 1;
    localparam int C_ENT_W      = C_ENT_V_W + C_ENT_RD_W + C_ENT_WEN_W + C_ENT_LOAD_W;

    // One in-flight register writer tracked in EX, MEM or WB
    typedef struct packed {
        logic                    v;
        logic [C_ENT_RD_W-1:0]   rd;
        logic                    wen;
        logic                    load;
    } shadow_t;

    // A source hits an in-flight writer only if it is really read and is not r0
    function automatic logic src_match(
        input logic                  used,
        input logic [C_REG_LOG-1:0]  rs,
        input shadow_t               ent
    );
        return used & ent.v & ent.wen & (ent.rd == rs) & (rs != '0);
    endfunction

endpackage : id_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/id_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_hazard_ctrl_if
//  Description : Decode-side bundle between the decode/register-file stage
//                (master) and the issue/hazard controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_hazard_ctrl_if
    import id_hazard_ctrl_pkg::*;
#(
    parameter int REG_LOG = C_REG_LOG,
    parameter int NSRC    = C_NSRC,
    parameter int CNT_W   = C_CNT_W
);
    logic                      id_valid;
    logic [NSRC*REG_LOG-1:0]   id_rs;
    logic [NSRC-1:0]           id_rs_used;
    logic [REG_LOG-1:0]        id_rd;
    logic                      id_wen;
    logic                      id_load;
    logic                      ex_ready;
    logic                      flush;
    logic                      id_ready;
    logic                      issue_valid;
    logic [NSRC*2-1:0]         fwd_sel;
    logic [CNT_W-1:0]          stall_cnt;

    // Decode stage side
    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_wen, id_load, ex_ready, flush,
        input  id_ready, issue_valid, fwd_sel, stall_cnt
    );

    // Hazard controller side
    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_wen, id_load, ex_ready, flush,
        output id_ready, issue_valid, fwd_sel, stall_cnt
    );

endinterface : id_hazard_ctrl_if
`default_nettype wire

// File: rtl/id_hazard_ctrl_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : id_fwd_match
//  Description : Compares one decoded source specifier against the EX/MEM/WB
//                shadow entries; returns the youngest-first forwarding select
//                and whether the EX hit is a load (load-use hazard).
//  Revision    : 1.0 - initial release
// ============================================================================
module id_fwd_match
    import id_hazard_ctrl_pkg::*;
(
    input  wire logic [C_REG_LOG-1:0] i_rs,
    input  wire logic                 i_used,
    input  wire shadow_t              i_ex,
    input  wire shadow_t              i_mem,
    input  wire shadow_t              i_wb,
    output logic [1:0]                o_fwd_sel,
    output logic                      o_ex_load_hit
);

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;

    assign w_hit_ex  = src_match(i_used, i_rs, i_ex);
    assign w_hit_mem = src_match(i_used, i_rs, i_mem);
    assign w_hit_wb  = src_match(i_used, i_rs, i_wb);

    // Youngest producer wins: EX, then MEM, then WB, otherwise register file
    always_comb begin
        o_fwd_sel = FWD_RF;
        if (w_hit_ex) begin
            o_fwd_sel = FWD_EX;
        end else if (w_hit_mem) begin
            o_fwd_sel = FWD_MEM;
        end else if (w_hit_wb) begin
            o_fwd_sel = FWD_WB;
        end
    end

    // A load in EX has no result yet, so an EX hit on it cannot be forwarded
    assign o_ex_load_hit = w_hit_ex & i_ex.load;

endmodule : id_fwd_match
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : id_hazard_ctrl
//  Description : Decode-stage issue controller. Shadows the EX/MEM/WB
//                register-write pipeline, produces per-source forwarding
//                selects, detects load-use hazards, gates issue into EX and
//                counts cycles lost to load-use stalls (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int REG_LOG = C_REG_LOG,
    parameter int NSRC    = C_NSRC,
    parameter int CNT_W   = C_CNT_W
)(
    input  wire logic          clk,
    input  wire logic          rst,
    id_hazard_ctrl_if.slave    bus
);

    // Shadow pipeline and stall counter
    shadow_t          ex_q,  ex_d;
    shadow_t          mem_q, mem_d;
    shadow_t          wb_q,  wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NSRC-1:0]   w_ex_load_hit;
    logic [NSRC*2-1:0] w_fwd_sel;
    logic              w_load_use;
    logic              w_id_ready;
    logic              w_issue_valid;

    // One comparator per source operand
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            id_fwd_match u_match (
                .i_rs          (bus.id_rs[gi*REG_LOG +: REG_LOG]),
                .i_used        (bus.id_rs_used[gi]),
                .i_ex          (ex_q),
                .i_mem         (mem_q),
                .i_wb          (wb_q),
                .o_fwd_sel     (w_fwd_sel[2*gi +: 2]),
                .o_ex_load_hit (w_ex_load_hit[gi])
            );
        end
    endgenerate

    // Hazard detection and issue gating; flush kills issue but not the stall
    always_comb begin
        w_load_use    = bus.id_valid & (|w_ex_load_hit);
        w_id_ready    = bus.ex_ready & ~w_load_use;
        w_issue_valid = bus.id_valid & w_id_ready & ~bus.flush;
    end

    assign bus.id_ready    = w_id_ready;
    assign bus.issue_valid = w_issue_valid;
    assign bus.fwd_sel     = w_fwd_sel;
    assign bus.stall_cnt   = stall_cnt_q;

    // Next state: shift the shadow pipe when downstream advances, else freeze
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.ex_ready) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (w_issue_valid) begin
                ex_d = '{v: 1'b1, rd: bus.id_rd, wen: bus.id_wen, load: bus.id_load};
            end else begin
                ex_d = '0;
            end
            if (w_load_use && !bus.flush && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule : id_hazard_ctrl
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_hazard_ctrl
//  Description : Scoreboard bench for id_hazard_ctrl. A driver applies
//                directed and random decode traffic, predicts the outputs
//                from a list of in-flight writers and queues them; a monitor
//                compares the DUT on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctrl;
    import id_hazard_ctrl_pkg::*;

    logic clk;
    logic rst;

    id_hazard_ctrl_if bus ();

    id_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of in-flight writers, youngest first
    typedef struct {
        bit v;
        int rd;
        bit wen;
        bit load;
    } ent_t;

    typedef struct {
        bit        rdy;
        bit        iss;
        bit [5:0]  sel;
        bit [31:0] cnt;
        int        cyc;
    } exp_t;

    ent_t      pipe[$];
    exp_t      sbq[$];
    bit [31:0] mcnt;
    int        cyc;
    int        n_chk;
    int        n_err;

    function automatic bit hits(input bit u, input int rs, input ent_t s);
        return u && s.v && s.wen && (s.rd == rs) && (rs != 0);
    endfunction

    task automatic model_clear();
        ent_t b;
        b = '{v: 1'b0, rd: 0, wen: 1'b0, load: 1'b0};
        pipe.delete();
        for (int k = 0; k < 3; k++) pipe.push_back(b);
        mcnt = 32'd0;
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, act, req);
        end
    endtask

    // One decode cycle: apply inputs, predict outputs, advance the model
    task automatic drive(input bit v, input int r0, input int r1, input int r2,
                         input bit [2:0] used, input int rd, input bit wen,
                         input bit ld, input bit rdy, input bit fl);
        int       rs;
        int       hit;
        bit [5:0] sel;
        bit       lu;
        bit       ready;
        bit       iss;
        ent_t     ne;
        exp_t     e;
        bus.id_valid   = v;
        bus.id_rs      = {r2[4:0], r1[4:0], r0[4:0]};
        bus.id_rs_used = used;
        bus.id_rd      = rd[4:0];
        bus.id_wen     = wen;
        bus.id_load    = ld;
        bus.ex_ready   = rdy;
        bus.flush      = fl;
        lu  = 1'b0;
        sel = '0;
        for (int i = 0; i < 3; i++) begin
            rs  = (i == 0) ? r0 : ((i == 1) ? r1 : r2);
            hit = -1;
            for (int a = 2; a >= 0; a--) begin
                if (hits(used[i], rs, pipe[a])) hit = a;
            end
            sel[2*i +: 2] = (hit < 0) ? 2'd0 : 2'(hit + 1);
            if (v && hit == 0 && pipe[0].load) lu = 1'b1;
        end
        ready = rdy && !lu;
        iss   = v && ready && !fl;
        e = '{rdy: ready, iss: iss, sel: sel, cnt: mcnt, cyc: cyc};
        sbq.push_back(e);
        if (!rst && rdy) begin
            if (iss) ne = '{v: 1'b1, rd: rd, wen: wen, load: ld};
            else     ne = '{v: 1'b0, rd: 0, wen: 1'b0, load: 1'b0};
            pipe.push_front(ne);
            void'(pipe.pop_back());
            if (lu && !fl && mcnt != 32'hFFFF_FFFF) mcnt++;
        end
        cyc++;
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge
    task automatic mid_reset();
        rst = 1'b1;
        model_clear();
        drive(1'b1, 10, 4, 0, 3'b011, 13, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    // Monitor: compare every queued prediction away from the rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("id_ready",    e.cyc, 32'(bus.id_ready),    32'(e.rdy));
                chk("issue_valid", e.cyc, 32'(bus.issue_valid), 32'(e.iss));
                chk("fwd_sel",     e.cyc, 32'(bus.fwd_sel),     32'(e.sel));
                chk("stall_cnt",   e.cyc, bus.stall_cnt,        e.cnt);
            end
        end
    end

    // Stimulus
    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        model_clear();
        rst            = 1'b1;
        bus.id_valid   = 1'b0;
        bus.id_rs      = '0;
        bus.id_rs_used = '0;
        bus.id_rd      = '0;
        bus.id_wen     = 1'b0;
        bus.id_load    = 1'b0;
        bus.ex_ready   = 1'b1;
        bus.flush      = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state, then add r3,r1,r2 into an empty pipe
        drive(1'b0, 0, 0, 0, 3'b000, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1, 2, 0, 3'b011, 3, 1'b1, 1'b0, 1'b1, 1'b0);

        // ALU forwarding from EX, MEM, WB
        drive(1'b1, 1, 0, 0, 3'b001, 5, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 5, 5, 0, 3'b011, 6, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 5, 0, 0, 3'b001, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 0, 5, 0, 3'b010, 9, 1'b1, 1'b0, 1'b1, 1'b0);

        // Load-use: one stall, then forward from MEM
        drive(1'b1, 1, 0, 0, 3'b001, 7, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 7, 2, 0, 3'b011, 11, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 7, 2, 0, 3'b011, 11, 1'b1, 1'b0, 1'b1, 1'b0);

        // r0 never forwards; unused source never forwards
        drive(1'b1, 1, 0, 0, 3'b001, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 0, 0, 0, 3'b011, 12, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1, 0, 0, 3'b001, 9, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 9, 9, 9, 3'b000, 12, 1'b1, 1'b0, 1'b1, 1'b0);

        // Freeze with r4 in MEM
        drive(1'b1, 1, 0, 0, 3'b001, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 0, 3'b000, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 4, 0, 0, 3'b001, 14, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4, 0, 0, 3'b001, 14, 1'b1, 1'b0, 1'b1, 1'b0);

        // Flush together with load-use, then reset mid-sequence
        drive(1'b1, 1, 0, 0, 3'b001, 10, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 10, 0, 0, 3'b001, 15, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1, 0, 0, 3'b001, 4, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 4, 0, 0, 3'b001, 3, 1'b1, 1'b0, 1'b1, 1'b0);
        mid_reset();
        drive(1'b1, 10, 4, 3, 3'b111, 16, 1'b1, 1'b0, 1'b1, 1'b0);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
            end else begin
                drive(($urandom_range(0, 9) < 8),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), ($urandom_range(0, 9) < 8),
                      ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 8),
                      ($urandom_range(0, 9) == 0));
            end
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 5 && sbq.size() > 0; w++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain pending=%0d exp=0", sbq.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_id_hazard_ctrl
`default_nettype wire
